// File: rtl/booth_seq_ctrl.sv
// Sequential signed 8x8 radix-2 Booth multiplier controller.
// Iterates one add/subtract-and-shift step per clock and hands back a 16-bit product.

module booth_step (
    input  logic [7:0] a_in,
    input  logic [7:0] q_in,
    input  logic       q1_in,
    input  logic [7:0] m_in,
    output logic [7:0] a_out,
    output logic [7:0] q_out,
    output logic       q1_out
);
    logic [7:0] sum;

    always_comb begin
        sum = a_in;
        case ({q_in[0], q1_in})
            2'b01:   sum = a_in + m_in;
            2'b10:   sum = a_in - m_in;
            default: sum = a_in;
        endcase
        a_out  = {sum[7], sum[7:1]};
        q_out  = {sum[0], q_in[7:1]};
        q1_out = q_in[0];
    end
endmodule

module booth_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  multiplicand,
    input  logic [7:0]  multiplier,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);
    localparam int unsigned W    = 8;
    localparam int unsigned PW   = 2 * W;
    localparam int unsigned CW   = 3;
    localparam logic [W-1:0] MIN_NEG = 8'h80;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, next_state;
    logic [W-1:0]  a_reg, q_reg, m_reg;
    logic          q1_reg;
    logic [CW-1:0] cnt;
    logic [PW-1:0] prod_reg;
    logic          busy_reg, done_reg;
    // Set when both operands are -128: product is a constant, delivered one cycle later
    logic          sp_pend;

    logic [W-1:0]  a_next, q_next, m_next;
    logic          q1_next;
    logic [CW-1:0] cnt_next;
    logic [PW-1:0] prod_next;
    logic          busy_next, done_next, sp_next;

    logic [W-1:0]  step_aout, step_qout;
    logic          step_q1out;

    booth_step u_step (
        .a_in   (a_reg),
        .q_in   (q_reg),
        .q1_in  (q1_reg),
        .m_in   (m_reg),
        .a_out  (step_aout),
        .q_out  (step_qout),
        .q1_out (step_q1out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            a_reg    <= '0;
            q_reg    <= '0;
            q1_reg   <= 1'b0;
            m_reg    <= '0;
            cnt      <= '0;
            prod_reg <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            sp_pend  <= 1'b0;
        end else begin
            state    <= next_state;
            a_reg    <= a_next;
            q_reg    <= q_next;
            q1_reg   <= q1_next;
            m_reg    <= m_next;
            cnt      <= cnt_next;
            prod_reg <= prod_next;
            busy_reg <= busy_next;
            done_reg <= done_next;
            sp_pend  <= sp_next;
        end
    end

    always_comb begin
        next_state = state;
        a_next     = a_reg;
        q_next     = q_reg;
        q1_next    = q1_reg;
        m_next     = m_reg;
        cnt_next   = cnt;
        prod_next  = prod_reg;
        sp_next    = 1'b0;

        case (state)
            IDLE: begin
                if (sp_pend) begin
                    prod_next  = 16'h4000;
                    next_state = DONE;
                end else if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                a_next   = step_aout;
                q_next   = step_qout;
                q1_next  = step_q1out;
                cnt_next = CW'(cnt + CW'(1));
                if (cnt == CW'(7)) begin
                    prod_next  = {step_aout, step_qout};
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = start ? RUN : IDLE;
            end
            default: next_state = IDLE;
        endcase

        // Operand load on accepted start; -128 is kept out of M to avoid A overflow
        if ((state == DONE || (state == IDLE && !sp_pend)) && start) begin
            a_next   = '0;
            q1_next  = 1'b0;
            cnt_next = '0;
            if (multiplicand != MIN_NEG) begin
                m_next = multiplicand;
                q_next = multiplier;
            end else if (multiplier != MIN_NEG) begin
                m_next = multiplier;
                q_next = MIN_NEG;
            end else begin
                sp_next    = 1'b1;
                next_state = IDLE;
            end
        end

        busy_next = (next_state == RUN);
        done_next = (next_state == DONE);
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign product = prod_reg;
endmodule
